// File: rtl/llapi_nes_pad.sv
// llapi_nes_pad
// Maps an LLAPI controller (type ID + 32-bit button vector) onto a standard
// NES pad. The mapped buttons feed an 8-bit joypad shift register that is
// driven by the core's strobe level and read pulses. A data-request pulse
// (LLAPI_SYNC) is raised on every strobe falling edge. This lets the LLAPI
// receiver poll in step with the game's pad sampling.
//
// Optional feature macro: LLAPI_NES_TURBO_EN
//   defined   - turbo counter/phase present. On SNES/PSX types, btn[2]
//               ORs into A and btn[0] ORs into B while the phase is high.
//   undefined - no turbo logic. btn[2]/btn[0] are ignored and TURBO_DIV
//               is unused.
//
// Ports
//   CLK_50M        in   system clock, rising edge
//   RESET_N        in   asynchronous active-low reset
//   LLAPI_EN       in   device-present flag from the receiver
//   LLAPI_TYPE     in   [7:0] controller type ID
//   LLAPI_BUTTONS  in   [31:0] button vector, 1 = pressed
//   JOY_STROBE     in   core latch level ($4016 bit0)
//   JOY_READ       in   one-cycle pulse per core read of this port
//   JOY_DATA       out  serial button bit, 1 = pressed
//   JOY_EN         out  registered copy of LLAPI_EN
//   LLAPI_SYNC     out  data-request pulse, SYNC_LEN cycles per request
//   BUTTONS_NES    out  [7:0] {Right,Left,Down,Up,Start,Select,B,A}

module llapi_nes_pad #(
    parameter int TURBO_DIV = 833333,
    parameter int SYNC_LEN  = 64
) (
    input  logic        CLK_50M,
    input  logic        RESET_N,
    input  logic        LLAPI_EN,
    input  logic [7:0]  LLAPI_TYPE,
    input  logic [31:0] LLAPI_BUTTONS,
    input  logic        JOY_STROBE,
    input  logic        JOY_READ,
    output logic        JOY_DATA,
    output logic        JOY_EN,
    output logic        LLAPI_SYNC,
    output logic [7:0]  BUTTONS_NES
);

    localparam int SYNC_W = $clog2(SYNC_LEN + 1);

    if (TURBO_DIV < 1 || SYNC_LEN < 1) begin : g_param_check
        $error("llapi_nes_pad: TURBO_DIV and SYNC_LEN must be at least 1");
    end

    logic              snes_psx;
    logic              genesis;
    logic              turbo_act;
    logic [7:0]        mapped;
    logic [7:0]        sr;
    logic              strobe_q;
    logic              strobe_fall;
    logic [SYNC_W-1:0] sync_cnt;

    // Bits of the LLAPI vector that have no NES equivalent.
    logic unused_bits;
    assign unused_bits = ^{LLAPI_BUTTONS[31:28], LLAPI_BUTTONS[23:14],
                           LLAPI_BUTTONS[8:6], LLAPI_BUTTONS[2], LLAPI_BUTTONS[0]};

    assign snes_psx = (LLAPI_TYPE == 8'd27) || (LLAPI_TYPE == 8'd65) ||
                      (LLAPI_TYPE == 8'd11) || (LLAPI_TYPE == 8'd12);
    assign genesis  = (LLAPI_TYPE == 8'd21) || (LLAPI_TYPE == 8'd22);

`ifdef LLAPI_NES_TURBO_EN
    localparam int TURBO_W = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;

    logic [TURBO_W-1:0] turbo_cnt;
    logic               turbo_phase;

    // Free-running regardless of LLAPI_EN, so the turbo cadence does not
    // restart when a pad is hot-plugged.
    always_ff @(posedge CLK_50M or negedge RESET_N) begin
        if (!RESET_N) begin
            turbo_cnt   <= '0;
            turbo_phase <= 1'b0;
        end else if (turbo_cnt == TURBO_W'(TURBO_DIV - 1)) begin
            turbo_cnt   <= '0;
            turbo_phase <= ~turbo_phase;
        end else begin
            turbo_cnt   <= turbo_cnt + TURBO_W'(1);
        end
    end

    assign turbo_act = snes_psx & turbo_phase;
`else
    assign turbo_act = 1'b0;
`endif

    always_comb begin
        mapped    = '0;
        mapped[7] = LLAPI_BUTTONS[24] | LLAPI_BUTTONS[13];   // Right
        mapped[6] = LLAPI_BUTTONS[25] | LLAPI_BUTTONS[12];   // Left
        mapped[5] = LLAPI_BUTTONS[26] | LLAPI_BUTTONS[11];   // Down
        mapped[4] = LLAPI_BUTTONS[27] | LLAPI_BUTTONS[10];   // Up
        mapped[3] = LLAPI_BUTTONS[5];                        // Start
        mapped[2] = LLAPI_BUTTONS[4];                        // Select
        mapped[1] = LLAPI_BUTTONS[1] | (turbo_act & LLAPI_BUTTONS[0]);
        // Genesis pads put their primary face button on btn[9].
        mapped[0] = (genesis ? LLAPI_BUTTONS[9] : LLAPI_BUTTONS[3]) |
                    (turbo_act & LLAPI_BUTTONS[2]);
    end

    always_ff @(posedge CLK_50M or negedge RESET_N) begin
        if (!RESET_N) begin
            BUTTONS_NES <= '0;
            JOY_EN      <= 1'b0;
        end else begin
            BUTTONS_NES <= LLAPI_EN ? mapped : 8'h00;
            JOY_EN      <= LLAPI_EN;
        end
    end

    // Serial joypad: ones shift in from the top, so a pad read past its
    // eighth bit returns 1 like an official controller.
    always_ff @(posedge CLK_50M or negedge RESET_N) begin
        if (!RESET_N) begin
            sr <= 8'h00;
        end else if (JOY_STROBE) begin
            sr <= BUTTONS_NES;
        end else if (JOY_READ) begin
            sr <= {1'b1, sr[7:1]};
        end
    end

    assign JOY_DATA = sr[0];

    assign strobe_fall = strobe_q & ~JOY_STROBE;

    // A falling edge during an active pulse reloads the counter, so the
    // request stretches without dropping low in between.
    always_ff @(posedge CLK_50M or negedge RESET_N) begin
        if (!RESET_N) begin
            strobe_q <= 1'b0;
            sync_cnt <= '0;
        end else begin
            strobe_q <= JOY_STROBE;
            if (strobe_fall) begin
                sync_cnt <= SYNC_W'(SYNC_LEN);
            end else if (sync_cnt != '0) begin
                sync_cnt <= sync_cnt - SYNC_W'(1);
            end
        end
    end

    assign LLAPI_SYNC = (sync_cnt != '0);

endmodule

// File: tb/tb_llapi_nes_pad.sv
module tb_llapi_nes_pad;

    localparam int TDIV = 4;
    localparam int SLEN = 64;

    logic        CLK_50M = 1'b0;
    logic        RESET_N = 1'b0;
    logic        LLAPI_EN = 1'b0;
    logic [7:0]  LLAPI_TYPE = 8'd0;
    logic [31:0] LLAPI_BUTTONS = 32'd0;
    logic        JOY_STROBE = 1'b0;
    logic        JOY_READ = 1'b0;
    logic        JOY_DATA;
    logic        JOY_EN;
    logic        LLAPI_SYNC;
    logic [7:0]  BUTTONS_NES;

    int n_pass = 0;
    int n_total = 0;

    llapi_nes_pad #(.TURBO_DIV(TDIV), .SYNC_LEN(SLEN)) dut (
        .CLK_50M(CLK_50M), .RESET_N(RESET_N), .LLAPI_EN(LLAPI_EN),
        .LLAPI_TYPE(LLAPI_TYPE), .LLAPI_BUTTONS(LLAPI_BUTTONS),
        .JOY_STROBE(JOY_STROBE), .JOY_READ(JOY_READ), .JOY_DATA(JOY_DATA),
        .JOY_EN(JOY_EN), .LLAPI_SYNC(LLAPI_SYNC), .BUTTONS_NES(BUTTONS_NES)
    );

    always #5 CLK_50M = ~CLK_50M;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int         m_edges;      // clock edges since reset release
    int         m_last_fall;  // edge index of latest strobe falling edge
    bit         m_fall_valid;
    logic [7:0] m_btn;
    logic [7:0] m_latched;    // byte captured by the last strobe
    int         m_reads;      // reads performed since that capture
    logic       m_prev_strobe;
    logic       m_joy_en;

    function automatic logic [7:0] nes_map(input logic [7:0] ty, input logic [31:0] b,
                                           input bit phase);
        logic a, bb;
        bit sp;
        sp = (ty == 27) || (ty == 65) || (ty == 11) || (ty == 12);
        a  = ((ty == 21) || (ty == 22)) ? b[9] : b[3];
        bb = b[1];
`ifdef LLAPI_NES_TURBO_EN
        if (sp && phase) begin
            a  = a | b[2];
            bb = bb | b[0];
        end
`else
        if (sp && phase && 1'b0) a = 1'b1;
`endif
        return {b[24] | b[13], b[25] | b[12], b[26] | b[11], b[27] | b[10],
                b[5], b[4], bb, a};
    endfunction

    function automatic logic exp_data();
        return (m_reads >= 8) ? 1'b1 : m_latched[m_reads];
    endfunction

    function automatic logic exp_sync();
        return m_fall_valid && ((m_edges - 1 - m_last_fall) < SLEN);
    endfunction

    always @(posedge CLK_50M or negedge RESET_N) begin
        if (!RESET_N) begin
            m_edges = 0; m_last_fall = 0; m_fall_valid = 0;
            m_btn = 8'h00; m_latched = 8'h00; m_reads = 0;
            m_prev_strobe = 1'b0; m_joy_en = 1'b0;
        end else begin
            bit phase;
            logic [7:0] nb;
            phase = ((m_edges / TDIV) % 2) == 1;
            nb = LLAPI_EN ? nes_map(LLAPI_TYPE, LLAPI_BUTTONS, phase) : 8'h00;
            if (JOY_STROBE) begin
                m_latched = m_btn;
                m_reads = 0;
            end else if (JOY_READ && m_reads < 8) begin
                m_reads++;
            end
            if (m_prev_strobe && !JOY_STROBE) begin
                m_last_fall = m_edges;
                m_fall_valid = 1;
            end
            m_prev_strobe = JOY_STROBE;
            m_btn = nb;
            m_joy_en = LLAPI_EN;
            m_edges++;
        end
    end

    always @(negedge CLK_50M) begin
        chk("cyc_buttons_nes", BUTTONS_NES, m_btn);
        chk("cyc_joy_en", JOY_EN, m_joy_en);
        chk("cyc_joy_data", JOY_DATA, exp_data());
        chk("cyc_llapi_sync", LLAPI_SYNC, exp_sync());
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLK_50M);
        #1;
    endtask

    task automatic strobe_latch();
        JOY_STROBE = 1'b1;
        repeat (3) tick();
        JOY_STROBE = 1'b0;
        tick();
    endtask

    task automatic read_pulse();
        JOY_READ = 1'b1;
        tick();
        JOY_READ = 1'b0;
        tick();
    endtask

    initial begin
        logic [9:0] seq;
        int cnt;
        int nrd;
        logic [7:0] types [8];

        repeat (3) tick();
        chk("rst_joy_data", JOY_DATA, 1'b0);
        chk("rst_joy_en", JOY_EN, 1'b0);
        chk("rst_sync", LLAPI_SYNC, 1'b0);
        chk("rst_buttons", BUTTONS_NES, 8'h00);
        RESET_N = 1'b1;
        tick();

        // SNES pad, A + Up: serial order A,B,Sel,Start,Up,... then ones.
        LLAPI_EN = 1'b1; LLAPI_TYPE = 8'd27; LLAPI_BUTTONS = 32'h0800_0008;
        strobe_latch();
        seq = 10'b11_0001_0001;
        for (int i = 0; i < 10; i++) begin
            chk("seq_type27", JOY_DATA, seq[i]);
            read_pulse();
        end

        // Genesis: A comes from btn[9], btn[3] has no effect.
        LLAPI_TYPE = 8'd21; LLAPI_BUTTONS = (32'd1 << 9) | (32'd1 << 3);
        tick();
        chk("genesis_a", BUTTONS_NES, 8'h01);
        LLAPI_BUTTONS = 32'd1 << 1;
        tick();
        chk("genesis_b", BUTTONS_NES, 8'h02);

        // Device absent: everything masked.
        LLAPI_TYPE = 8'd27; LLAPI_BUTTONS = 32'hFFFF_FFFF; LLAPI_EN = 1'b0;
        tick();
        chk("en_off_buttons", BUTTONS_NES, 8'h00);
        chk("en_off_joy_en", JOY_EN, 1'b0);
        strobe_latch();
        for (int i = 0; i < 9; i++) begin
            chk("en_off_seq", JOY_DATA, (i < 8) ? 1'b0 : 1'b1);
            read_pulse();
        end

        // Single sync pulse length.
        repeat (70) tick();
        JOY_STROBE = 1'b1;
        tick();
        chk("sync_idle", LLAPI_SYNC, 1'b0);
        JOY_STROBE = 1'b0;
        tick();
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (LLAPI_SYNC) cnt++;
            tick();
        end
        chk("sync_len", cnt, SLEN);

        // Second falling edge 10 cycles after the first stretches the pulse.
        JOY_STROBE = 1'b1;
        tick();
        JOY_STROBE = 1'b0;
        tick();
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (LLAPI_SYNC) cnt++;
            JOY_STROBE = (i == 8);
            tick();
        end
        chk("sync_extend", cnt, SLEN + 10);

        // Turbo on a PSX pad.
        LLAPI_EN = 1'b1; LLAPI_TYPE = 8'd65; LLAPI_BUTTONS = 32'h4;
        repeat (2) tick();
        cnt = 0;
        for (int i = 0; i < 4 * TDIV; i++) begin
            if (BUTTONS_NES[0]) cnt++;
            tick();
        end
`ifdef LLAPI_NES_TURBO_EN
        chk("turbo_ones", cnt, 2 * TDIV);
`else
        chk("turbo_ones", cnt, 0);
`endif

        // Async reset mid-read.
        LLAPI_TYPE = 8'd27; LLAPI_BUTTONS = 32'h28;   // A + Start
        strobe_latch();
        repeat (3) read_pulse();
        chk("pre_reset_start", JOY_DATA, 1'b1);
        RESET_N = 1'b0;
        #1;
        chk("reset_mid_read", JOY_DATA, 1'b0);
        repeat (2) tick();
        RESET_N = 1'b1;
        tick();
        strobe_latch();
        chk("post_reset_a", JOY_DATA, 1'b1);

        // Randomized frames checked by the per-cycle model.
        types = '{8'd27, 8'd65, 8'd11, 8'd12, 8'd21, 8'd22, 8'd18, 8'd0};
        for (int f = 0; f < 250; f++) begin
            types[7] = 8'($urandom);
            LLAPI_TYPE = types[$urandom_range(0, 7)];
            LLAPI_BUTTONS = $urandom;
            LLAPI_EN = ($urandom_range(0, 9) != 0);
            JOY_STROBE = 1'b1;
            repeat ($urandom_range(1, 4)) begin
                JOY_READ = $urandom_range(0, 1);
                tick();
            end
            JOY_STROBE = 1'b0;
            JOY_READ = ($urandom_range(0, 3) == 0);
            tick();
            nrd = $urandom_range(6, 20);
            for (int k = 0; k < nrd; k++) begin
                JOY_READ = $urandom_range(0, 1);
                if ($urandom_range(0, 15) == 0) LLAPI_BUTTONS = $urandom;
                if ($urandom_range(0, 31) == 0) LLAPI_EN = ~LLAPI_EN;
                JOY_STROBE = ($urandom_range(0, 40) == 0);
                tick();
            end
            JOY_READ = 1'b0;
            JOY_STROBE = 1'b0;
            if (f == 120) begin
                RESET_N = 1'b0;
                repeat (2) tick();
                RESET_N = 1'b1;
            end
            if ($urandom_range(0, 9) == 0) repeat (SLEN + 5) tick();
            else tick();
        end
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
